fp_div_round: RTL and testbench

- Post-processing stage directly downstream of radix_16_divider_uint in the single-precision FP divide path.
- Captures operand sign, exponents and special-case class when the divide starts, then waits for the divider's done pulse.
- Normalises the integer quotient, rounds to nearest-even, handles overflow/underflow and emits a packed IEEE-754 binary32 result with flags over a valid/ready handshake.

---
 rtl/fp_pkg.sv | 31 +++
 rtl/fp_round_rne.sv | 53 +++++
 rtl/fp_div_round.sv | 184 ++++++++++++++++++
 tb/tb_fp_div_round.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared constants and encodings for the single-precision FP datapath.
// Used by the divide post-processing stage and the rounding helper.
package fp_pkg;

    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        CLS_NORMAL = 2'b00,
        CLS_ZERO   = 2'b01,
        CLS_INF    = 2'b10,
        CLS_NAN    = 2'b11
    } fp_class_e;

    localparam int FLG_INVALID = 4;
    localparam int FLG_DIVZ    = 3;
    localparam int FLG_OVF     = 2;
    localparam int FLG_UNF     = 1;
    localparam int FLG_INX     = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_DIV,
        ST_NORM,
        ST_ROUND,
        ST_OUT
    } div_state_e;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even and range check of a normalised significand.
// Flushes to zero below the normal range, saturates to infinity above it.
module fp_round_rne
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 24
) (
    input  logic                   sign,
    input  logic [MAN_W-1:0]       man,
    input  logic                   guard,
    input  logic                   sticky,
    input  logic [EXP_W+1:0]       exp_in,
    output logic [EXP_W+MAN_W-1:0] result,
    output logic                   overflow,
    output logic                   underflow,
    output logic                   inexact
);

    logic             round_up;
    logic [MAN_W:0]   sum;
    logic [MAN_W-1:0] man_r;
    logic [EXP_W+1:0] exp_r;
    logic             unused_hidden;

    assign unused_hidden = man_r[MAN_W-1];

    always_comb begin
        round_up  = guard & (sticky | man[0]);
        sum       = {1'b0, man} + {{MAN_W{1'b0}}, round_up};
        man_r     = sum[MAN_W-1:0];
        exp_r     = exp_in;
        overflow  = 1'b0;
        underflow = 1'b0;
        inexact   = guard | sticky;
        // a carry out of the significand means it rounded up to 2.0
        if (sum[MAN_W]) begin
            man_r = sum[MAN_W:1];
            exp_r = exp_in + (EXP_W+2)'(1);
        end
        result = {sign, exp_r[EXP_W-1:0], man_r[MAN_W-2:0]};
        if (!exp_r[EXP_W+1] && exp_r[EXP_W:0] >= (EXP_W+1)'(EXP_MAX)) begin
            overflow = 1'b1;
            inexact  = 1'b1;
            result   = {sign, {EXP_W{1'b1}}, {(MAN_W-1){1'b0}}};
        end else if (exp_r[EXP_W+1] || exp_r == '0) begin
            underflow = 1'b1;
            inexact   = 1'b1;
            result    = {sign, {(EXP_W+MAN_W-1){1'b0}}};
        end
    end

endmodule

// File: rtl/fp_div_round.sv
// FP divide post-processing: captures operand info, waits for the integer
// divider, normalises, rounds and hands out a binary32 result.
module fp_div_round
    import fp_pkg::*;
#(
    parameter int QF    = 26,
    parameter int EXP_W = 8,
    parameter int MAN_W = 24
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   sign_in,
    input  logic [EXP_W-1:0]       exp_a,
    input  logic [EXP_W-1:0]       exp_b,
    input  logic [1:0]             special_in,
    input  logic [1:0]             flags_in,
    input  logic                   div_done,
    input  logic [51:0]            div_quotient,
    input  logic [MAN_W-1:0]       div_reminder,
    output logic [EXP_W+MAN_W-1:0] result,
    output logic [4:0]             flags,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic                   busy
);

    localparam int E_W = EXP_W + 2;
    localparam int R_W = EXP_W + MAN_W;

    div_state_e       state_q, state_d;
    logic             sign_q, sign_d;
    logic [EXP_W-1:0] exp_a_q, exp_a_d;
    logic [EXP_W-1:0] exp_b_q, exp_b_d;
    logic [1:0]       fin_q, fin_d;
    logic [QF:0]      q_q, q_d;
    logic             st0_q, st0_d;
    logic [MAN_W-1:0] m_q, m_d;
    logic             g_q, g_d;
    logic             s_q, s_d;
    logic [E_W-1:0]   e_q, e_d;
    logic [R_W-1:0]   result_q, result_d;
    logic [4:0]       flags_q, flags_d;

    logic [QF:0]      q_n;
    logic [E_W-1:0]   e_calc;
    logic [R_W-1:0]   rnd_result;
    logic             rnd_ovf;
    logic             rnd_unf;
    logic             rnd_inx;
    logic             unused_q_hi;

    assign unused_q_hi = ^div_quotient[51:QF+1];

    fp_round_rne #(
        .EXP_W(EXP_W),
        .MAN_W(MAN_W)
    ) u_round (
        .sign      (sign_q),
        .man       (m_q),
        .guard     (g_q),
        .sticky    (s_q),
        .exp_in    (e_q),
        .result    (rnd_result),
        .overflow  (rnd_ovf),
        .underflow (rnd_unf),
        .inexact   (rnd_inx)
    );

    always_comb begin
        // quotient lies in [2^(QF-1), 2^(QF+1)); shift the short case up
        q_n    = q_q[QF] ? q_q : {q_q[QF-1:0], 1'b0};
        e_calc = {2'b00, exp_a_q} - {2'b00, exp_b_q} + E_W'(BIAS);
        if (!q_q[QF]) begin
            e_calc = e_calc - E_W'(1);
        end
    end

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_a_d  = exp_a_q;
        exp_b_d  = exp_b_q;
        fin_d    = fin_q;
        q_d      = q_q;
        st0_d    = st0_q;
        m_d      = m_q;
        g_d      = g_q;
        s_d      = s_q;
        e_d      = e_q;
        result_d = result_q;
        flags_d  = flags_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sign_d  = sign_in;
                    exp_a_d = exp_a;
                    exp_b_d = exp_b;
                    fin_d   = flags_in;
                    flags_d = {flags_in, 3'b000};
                    unique case (fp_class_e'(special_in))
                        CLS_NORMAL: state_d = ST_WAIT_DIV;
                        CLS_ZERO: begin
                            result_d = {sign_in, {(R_W-1){1'b0}}};
                            state_d  = ST_OUT;
                        end
                        CLS_INF: begin
                            result_d = {sign_in, {EXP_W{1'b1}},
                                        {(MAN_W-1){1'b0}}};
                            state_d  = ST_OUT;
                        end
                        CLS_NAN: begin
                            result_d = QNAN;
                            state_d  = ST_OUT;
                        end
                    endcase
                end
            end
            ST_WAIT_DIV: begin
                if (div_done) begin
                    q_d     = div_quotient[QF:0];
                    st0_d   = |div_reminder;
                    state_d = ST_NORM;
                end
            end
            ST_NORM: begin
                m_d     = q_n[QF -: MAN_W];
                g_d     = q_n[QF-MAN_W];
                s_d     = (|q_n[QF-MAN_W-1:0]) | st0_q;
                e_d     = e_calc;
                state_d = ST_ROUND;
            end
            ST_ROUND: begin
                result_d = rnd_result;
                flags_d  = {fin_q, rnd_ovf, rnd_unf, rnd_inx};
                state_d  = ST_OUT;
            end
            ST_OUT: begin
                if (result_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            sign_q   <= 1'b0;
            exp_a_q  <= '0;
            exp_b_q  <= '0;
            fin_q    <= '0;
            q_q      <= '0;
            st0_q    <= 1'b0;
            m_q      <= '0;
            g_q      <= 1'b0;
            s_q      <= 1'b0;
            e_q      <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_a_q  <= exp_a_d;
            exp_b_q  <= exp_b_d;
            fin_q    <= fin_d;
            q_q      <= q_d;
            st0_q    <= st0_d;
            m_q      <= m_d;
            g_q      <= g_d;
            s_q      <= s_d;
            e_q      <= e_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign result       = result_q;
    assign flags        = flags_q;
    assign result_valid = (state_q == ST_OUT);
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fp_div_round.sv
// Self-checking bench for fp_div_round: directed table, randomized divides
// against an exact-arithmetic model, and handshake/reset sequences.
module tb_fp_div_round;

    localparam int QF = 26;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        sign_in;
    logic [7:0]  exp_a;
    logic [7:0]  exp_b;
    logic [1:0]  special_in;
    logic [1:0]  flags_in;
    logic        div_done;
    logic [51:0] div_quotient;
    logic [23:0] div_reminder;
    logic [31:0] result;
    logic [4:0]  flags;
    logic        result_valid;
    logic        result_ready;
    logic        busy;

    always #5 clk = ~clk;

    fp_div_round dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .sign_in      (sign_in),
        .exp_a        (exp_a),
        .exp_b        (exp_b),
        .special_in   (special_in),
        .flags_in     (flags_in),
        .div_done     (div_done),
        .div_quotient (div_quotient),
        .div_reminder (div_reminder),
        .result       (result),
        .flags        (flags),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .busy         (busy)
    );

    typedef struct {
        logic        sign;
        logic [7:0]  ea;
        logic [7:0]  eb;
        logic [1:0]  sp;
        logic [1:0]  fin;
        logic [51:0] q;
        logic [23:0] rem;
        logic [31:0] res;
        logic [4:0]  flg;
    } vec_t;

    vec_t vecs[11];
    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Exact model: numerator T = 2Q + sticky represents the true quotient
    // scaled by 2^(QF+1); round its top 24 bits to nearest even.
    function automatic void model(input logic s, input int ea, input int eb,
                                  input longint q, input longint rem,
                                  output logic [31:0] r,
                                  output logic [4:0] f);
        longint t, mant, low, half;
        int p, e;
        logic inx;
        t = 2 * q + ((rem != 0) ? 1 : 0);
        p = 0;
        for (int i = 0; i < 63; i++) if (t[i]) p = i;
        mant = t >>> (p - 23);
        low  = t & ((64'sd1 <<< (p - 23)) - 1);
        half = 64'sd1 <<< (p - 24);
        inx  = (low != 0);
        if (low > half || (low == half && mant[0])) mant = mant + 1;
        e = ea - eb + 127 + p - (QF + 1);
        if (mant == (64'sd1 <<< 24)) begin
            mant = mant >>> 1;
            e = e + 1;
        end
        if (e >= 255) begin
            r = {s, 8'hFF, 23'h0};
            f = 5'b00101;
        end else if (e <= 0) begin
            r = {s, 31'h0};
            f = 5'b00011;
        end else begin
            r = {s, e[7:0], mant[22:0]};
            f = {4'b0000, inx};
        end
    endfunction

    task automatic run_op(input vec_t v, input string tag, input int hold);
        @(negedge clk);
        start = 1'b1;
        sign_in = v.sign;
        exp_a = v.ea;
        exp_b = v.eb;
        special_in = v.sp;
        flags_in = v.fin;
        @(negedge clk);
        start = 1'b0;
        if (v.sp != 2'b00) begin
            chk({tag, " valid_k1"}, 32'(result_valid), 32'd1);
        end else begin
            chk({tag, " busy"}, 32'(busy), 32'd1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            div_done = 1'b1;
            div_quotient = v.q;
            div_reminder = v.rem;
            @(negedge clk);
            div_done = 1'b0;
            @(negedge clk);
            chk({tag, " valid_k1"}, 32'(result_valid), 32'd0);
            @(negedge clk);
            chk({tag, " valid_k2"}, 32'(result_valid), 32'd1);
        end
        chk({tag, " result"}, result, v.res);
        chk({tag, " flags"}, 32'(flags), 32'(v.flg));
        for (int i = 0; i < hold; i++) begin
            start = 1'b1;
            special_in = 2'b11;
            flags_in = 2'b11;
            sign_in = ~v.sign;
            @(negedge clk);
            chk({tag, " hold valid"}, 32'(result_valid), 32'd1);
            chk({tag, " hold result"}, result, v.res);
            chk({tag, " hold flags"}, 32'(flags), 32'(v.flg));
        end
        start = 1'b0;
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        chk({tag, " valid_drop"}, 32'(result_valid), 32'd0);
        chk({tag, " idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        logic [31:0] mr;
        logic [4:0] mf;
        longint ma, mb, num;

        vecs[0]  = '{0, 129, 128, 2'b00, 2'b00, 52'h4000000, 24'd0,
                     32'h40000000, 5'b00000};
        vecs[1]  = '{0, 127, 128, 2'b00, 2'b00, 52'h2AAAAAA, 24'd2,
                     32'h3EAAAAAB, 5'b00001};
        vecs[2]  = '{0, 254, 1, 2'b00, 2'b00, 52'h4000000, 24'd0,
                     32'h7F800000, 5'b00101};
        vecs[3]  = '{1, 254, 1, 2'b00, 2'b00, 52'h4000000, 24'd0,
                     32'hFF800000, 5'b00101};
        vecs[4]  = '{0, 1, 254, 2'b00, 2'b00, 52'h4000000, 24'd0,
                     32'h00000000, 5'b00011};
        vecs[5]  = '{0, 0, 0, 2'b11, 2'b10, 52'h0, 24'd0,
                     32'h7FC00000, 5'b10000};
        vecs[6]  = '{1, 0, 0, 2'b01, 2'b00, 52'h0, 24'd0,
                     32'h80000000, 5'b00000};
        vecs[7]  = '{0, 0, 0, 2'b10, 2'b01, 52'h0, 24'd0,
                     32'h7F800000, 5'b01000};
        vecs[8]  = '{0, 127, 127, 2'b00, 2'b00, 52'h7FFFFFF, 24'd1,
                     32'h40000000, 5'b00001};
        vecs[9]  = '{0, 127, 127, 2'b00, 2'b00, 52'h4000004, 24'd0,
                     32'h3F800000, 5'b00001};
        vecs[10] = '{0, 127, 127, 2'b00, 2'b00, 52'h400000C, 24'd0,
                     32'h3F800002, 5'b00001};

        reset = 1'b1;
        start = 1'b0;
        sign_in = 1'b0;
        exp_a = '0;
        exp_b = '0;
        special_in = '0;
        flags_in = '0;
        div_done = 1'b0;
        div_quotient = '0;
        div_reminder = '0;
        result_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst result", result, 32'h0);
        chk("rst flags", 32'(flags), 32'h0);
        chk("rst valid", 32'(result_valid), 32'h0);
        chk("rst busy", 32'(busy), 32'h0);
        reset = 1'b0;

        // spurious div_done while idle
        div_done = 1'b1;
        div_quotient = 52'h4000000;
        @(negedge clk);
        div_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("spurious valid", 32'(result_valid), 32'd0);
            chk("spurious busy", 32'(busy), 32'd0);
        end

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i), 0);
        end

        for (int i = 0; i < 40; i++) begin
            ma = longint'($urandom_range(24'hFFFFFF, 24'h800000));
            mb = longint'($urandom_range(24'hFFFFFF, 24'h800000));
            num = ma <<< QF;
            v.sign = 1'($urandom_range(0, 1));
            v.ea = 8'($urandom_range(1, 254));
            v.eb = 8'($urandom_range(1, 254));
            if (i % 4 == 0) v.eb = 8'($urandom_range(100, 154));
            if (i % 4 == 1) v.ea = 8'($urandom_range(100, 154));
            v.sp = 2'b00;
            v.fin = 2'b00;
            v.q = 52'(num / mb);
            v.rem = 24'(num % mb);
            model(v.sign, int'(v.ea), int'(v.eb), longint'(v.q),
                  longint'(v.rem), mr, mf);
            v.res = mr;
            v.flg = mf;
            run_op(v, $sformatf("rand%0d", i), 0);
        end

        // backpressure with start pulses ignored in OUT
        run_op(vecs[1], "bp", 5);

        // reset abandons an operation waiting on the divider
        @(negedge clk);
        start = 1'b1;
        sign_in = 1'b1;
        exp_a = 8'd130;
        exp_b = 8'd120;
        special_in = 2'b00;
        flags_in = 2'b00;
        @(negedge clk);
        start = 1'b0;
        chk("wait busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid rst result", result, 32'h0);
        chk("mid rst flags", 32'(flags), 32'h0);
        chk("mid rst valid", 32'(result_valid), 32'd0);
        chk("mid rst busy", 32'(busy), 32'd0);
        div_done = 1'b1;
        div_quotient = 52'h4000000;
        div_reminder = 24'd0;
        @(negedge clk);
        div_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post rst valid", 32'(result_valid), 32'd0);
            chk("post rst busy", 32'(busy), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
